// File: rtl/mem_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, access sizes,
// bus direction encoding and the per-requester transfer descriptor.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } dataType_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Requester slots in the req/gnt vectors
    localparam int GNT_FETCH = 0;
    localparam int GNT_DATA  = 1;

    typedef struct packed {
        logic      rw;
        logic [7:0] addr;
        logic [31:0] wdata;
        dataType_t dtype;
    } memReq_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester always wins, a tie goes to
// the slot that was not granted last (last: 0 = slot 0, 1 = slot 1).
module rr_arb2 (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

    gntOneHot: assert property (@(posedge Clk) disable iff (!Reset_n) !(&gnt));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one ram256x32
// MOV/MOC handshake, with a cycle timeout while waiting for the RAM.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IReq,
    input  logic [7:0]  IAddr,
    output logic [31:0] IRdata,
    output logic        IDone,
    input  logic        DReq,
    input  logic        DRW,
    input  logic [7:0]  DAddr,
    input  logic [31:0] DWdata,
    input  logic [1:0]  DType,
    output logic [31:0] DRdata,
    output logic        DDone,
    output logic        Err,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [7:0]  Address,
    output logic [31:0] DataIn,
    output logic [1:0]  DataType,
    input  logic [31:0] DataOut,
    input  logic        MOC
);

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    arbState_t  state;
    logic [3:0] cnt;
    logic       lastGnt;
    logic       curData;
    logic [1:0] reqVec;
    logic [1:0] gnt;
    memReq_t    selReq;

    assign reqVec[GNT_FETCH] = IReq;
    assign reqVec[GNT_DATA]  = DReq;

    rr_arb2 uArb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .req     (reqVec),
        .last    (lastGnt),
        .gnt     (gnt)
    );

    // Fetches are always full-word reads with no write data
    always_comb begin
        selReq = '{rw: RW_READ, addr: IAddr, wdata: '0, dtype: WORD};
        if (gnt[GNT_DATA])
            selReq = '{rw: DRW, addr: DAddr, wdata: DWdata, dtype: dataType_t'(DType)};
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            MOV       <= 1'b0;
            ReadWrite <= RW_READ;
            Address   <= '0;
            DataIn    <= '0;
            DataType  <= WORD;
            IRdata    <= '0;
            DRdata    <= '0;
            IDone     <= 1'b0;
            DDone     <= 1'b0;
            Err       <= 1'b0;
            cnt       <= '0;
            lastGnt   <= 1'b1;
            curData   <= 1'b0;
        end else begin
            IDone <= 1'b0;
            DDone <= 1'b0;
            Err   <= 1'b0;
            case (state)
                IDLE: begin
                    // A RAM still finishing a previous cycle must drop MOC first
                    if (|gnt && !MOC) begin
                        Address   <= selReq.addr;
                        ReadWrite <= selReq.rw;
                        DataIn    <= selReq.wdata;
                        DataType  <= selReq.dtype;
                        MOV       <= 1'b1;
                        curData   <= gnt[GNT_DATA];
                        lastGnt   <= gnt[GNT_DATA];
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (MOC) begin
                        MOV   <= 1'b0;
                        state <= RELEASE;
                        if (curData) begin
                            DDone <= 1'b1;
                            if (ReadWrite == RW_READ)
                                DRdata <= DataOut;
                        end else begin
                            IDone  <= 1'b1;
                            IRdata <= DataOut;
                        end
                    end else if (cnt == CNT_LAST) begin
                        MOV   <= 1'b0;
                        Err   <= 1'b1;
                        state <= RELEASE;
                        if (curData)
                            DDone <= 1'b1;
                        else
                            IDone <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    if (!MOC)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
